// File: rtl/cpu_register_file_write_arbiter.sv
// Purpose: round-robin arbiter for register-file write ports, plus a full-file clear sweep.
// Latency: one cycle from an accepted request (or a sweep counter value) to the write outputs.
// Backpressure: one-hot valid/ready grant in IDLE; ready is held all-zero during a sweep and in reset.
module cpu_register_file_write_arbiter #(
  parameter int NUMBER_OF_REGISTERS  = 256,
  parameter int NUMBER_OF_REQUESTERS = 4,
  localparam int AW = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                              clock_in,
  input  logic                              reset_in,
  input  logic [NUMBER_OF_REQUESTERS-1:0]    request_valid_in,
  input  logic [NUMBER_OF_REQUESTERS*AW-1:0] request_address_in,
  input  logic [NUMBER_OF_REQUESTERS*8-1:0]  request_data_in,
  output logic [NUMBER_OF_REQUESTERS-1:0]    request_ready_out,
  input  logic                              clear_start_in,
  output logic                              write_enable_out,
  output logic [AW-1:0]                     write_register_address_out,
  output logic [7:0]                        write_data_out,
  output logic                              busy_out,
  output logic                              clear_done_out
);

  localparam int PW = $clog2(NUMBER_OF_REQUESTERS);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_pointer;
  logic [AW-1:0] clear_counter;

  logic [NUMBER_OF_REQUESTERS-1:0] grant;
  logic [PW-1:0]                   grant_index;
  logic                            grant_found;
  logic [PW:0]                     candidate;
  logic [PW-1:0]                   next_pointer;

  logic [AW-1:0] request_address [NUMBER_OF_REQUESTERS];
  logic [7:0]    request_data    [NUMBER_OF_REQUESTERS];

  // Split the packed request buses into per-requester fields.
  for (genvar k = 0; k < NUMBER_OF_REQUESTERS; k++) begin : g_unpack
    assign request_address[k] = request_address_in[k*AW +: AW];
    assign request_data[k]    = request_data_in[k*8 +: 8];
  end

  // Round-robin search from the pointer upward, wrapping; only in IDLE and out of reset.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_found = 1'b0;
    candidate   = '0;
    if (state == IDLE && !reset_in) begin
      for (int i = 0; i < NUMBER_OF_REQUESTERS; i++) begin
        candidate = {1'b0, rr_pointer} + (PW+1)'(i);
        if (candidate >= (PW+1)'(NUMBER_OF_REQUESTERS)) begin
          candidate = candidate - (PW+1)'(NUMBER_OF_REQUESTERS);
        end
        if (!grant_found && request_valid_in[candidate[PW-1:0]]) begin
          grant_found = 1'b1;
          grant_index = candidate[PW-1:0];
        end
      end
    end
    if (grant_found) begin
      grant[grant_index] = 1'b1;
    end
  end

  assign request_ready_out = grant;
  assign next_pointer      = (grant_index == PW'(NUMBER_OF_REQUESTERS - 1)) ? '0
                                                                           : grant_index + PW'(1);

  // State machine: registers the granted write or the sweep write, and sequences the clear.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state                      <= IDLE;
      rr_pointer                 <= '0;
      clear_counter              <= '0;
      write_enable_out           <= 1'b0;
      write_register_address_out <= '0;
      write_data_out             <= '0;
      busy_out                   <= 1'b0;
      clear_done_out             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clear_done_out <= 1'b0;
          if (grant_found) begin
            // Grant is one-hot and ready implies valid, so this is the transfer.
            write_enable_out           <= 1'b1;
            write_register_address_out <= request_address[grant_index];
            write_data_out             <= request_data[grant_index];
            rr_pointer                 <= next_pointer;
          end else begin
            write_enable_out <= 1'b0;
          end
          if (clear_start_in) begin
            state         <= CLEAR;
            clear_counter <= '0;
            busy_out      <= 1'b1;
          end
        end
        CLEAR: begin
          // One zero-write per cycle; the pointer stays frozen and clear_start_in is ignored.
          write_enable_out           <= 1'b1;
          write_register_address_out <= clear_counter;
          write_data_out             <= 8'h00;
          if (clear_counter == AW'(NUMBER_OF_REGISTERS - 1)) begin
            state          <= IDLE;
            clear_counter  <= '0;
            busy_out       <= 1'b0;
            clear_done_out <= 1'b1;
          end else begin
            clear_counter  <= clear_counter + AW'(1);
            clear_done_out <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          write_enable_out <= 1'b0;
          busy_out         <= 1'b0;
          clear_done_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_register_file_write_arbiter.sv
// Purpose: scoreboard bench for the register-file write arbiter and its clear sweep.
// Latency: expected writes are queued at stimulus time and popped when the DUT shows a write.
// Backpressure: ready is checked per cycle against hand-computed one-hot grants.
module tb_cpu_register_file_write_arbiter;

  logic        clock_in;
  logic        reset_in;
  logic [3:0]  request_valid_in;
  logic [31:0] request_address_in;
  logic [31:0] request_data_in;
  logic [3:0]  request_ready_out;
  logic        clear_start_in;
  logic        write_enable_out;
  logic [7:0]  write_register_address_out;
  logic [7:0]  write_data_out;
  logic        busy_out;
  logic        clear_done_out;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       done;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  compared   = 0;
  int  mismatched = 0;

  cpu_register_file_write_arbiter #(
    .NUMBER_OF_REGISTERS (256),
    .NUMBER_OF_REQUESTERS(4)
  ) dut (
    .clock_in                  (clock_in),
    .reset_in                  (reset_in),
    .request_valid_in          (request_valid_in),
    .request_address_in        (request_address_in),
    .request_data_in           (request_data_in),
    .request_ready_out         (request_ready_out),
    .clear_start_in            (clear_start_in),
    .write_enable_out          (write_enable_out),
    .write_register_address_out(write_register_address_out),
    .write_data_out            (write_data_out),
    .busy_out                  (busy_out),
    .clear_done_out            (clear_done_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the expected queue.
  always @(negedge clock_in) begin
    if (write_enable_out === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: addr %0h data %0h done %0b, expected no write",
                 write_register_address_out, write_data_out, clear_done_out);
      end else begin
        mon_e = exp_q.pop_front();
        if ({write_register_address_out, write_data_out, clear_done_out} !== mon_e) begin
          mismatched++;
          $display("FAIL write: addr %0h data %0h done %0b, expected addr %0h data %0h done %0b",
                   write_register_address_out, write_data_out, clear_done_out,
                   mon_e.addr, mon_e.data, mon_e.done);
        end
      end
    end else if (clear_done_out === 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL stray_done: clear_done_out 1 without a write, expected 0");
    end
  end

  // One cycle of stimulus: drive after the edge, check ready mid-cycle, queue the granted write.
  task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] d,
                      input logic clr, input logic rst, input logic [3:0] exp_rdy,
                      input string name);
    @(posedge clock_in);
    #1;
    request_valid_in   = v;
    request_address_in = a;
    request_data_in    = d;
    clear_start_in     = clr;
    reset_in           = rst;
    @(negedge clock_in);
    #1;
    chk(name, 32'(request_ready_out), 32'(exp_rdy));
    for (int k = 0; k < 4; k++) begin
      if (exp_rdy[k]) exp_q.push_back('{addr: a[k*8 +: 8], data: d[k*8 +: 8], done: 1'b0});
    end
  endtask

  task automatic push_sweep();
    for (int r = 0; r < 256; r++) begin
      exp_q.push_back('{addr: 8'(r), data: 8'h00, done: (r == 255)});
    end
  endtask

  localparam logic [31:0] A5    = 32'h05050505;
  localparam logic [31:0] D1X   = 32'h13121110;
  localparam logic [31:0] A_FF  = 32'h00FF0000;
  localparam logic [31:0] D_A5  = 32'h00A50000;
  localparam logic [31:0] A_MIX = 32'h33221100;
  localparam logic [31:0] D_MIX = 32'hD3C2B1A0;

  initial begin
    reset_in           = 1'b1;
    request_valid_in   = '0;
    request_address_in = '0;
    request_data_in    = '0;
    clear_start_in     = 1'b0;

    // Reset wins over valid and clear; ready stays zero while reset is high.
    step(4'b1111, A5, D1X, 1'b1, 1'b1, 4'b0000, "rst_ready0");
    step(4'b1111, A5, D1X, 1'b0, 1'b1, 4'b0000, "rst_ready1");
    chk("rst_we",   32'(write_enable_out), 32'd0);
    chk("rst_addr", 32'(write_register_address_out), 32'd0);
    chk("rst_data", 32'(write_data_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(clear_done_out), 32'd0);

    // All requesters valid: strict rotation 0,1,2,3,0.
    step(4'b1111, A5, D1X, 1'b0, 1'b0, 4'b0001, "rot_g0");
    step(4'b1111, A5, D1X, 1'b0, 1'b0, 4'b0010, "rot_g1");
    step(4'b1111, A5, D1X, 1'b0, 1'b0, 4'b0100, "rot_g2");
    step(4'b1111, A5, D1X, 1'b0, 1'b0, 4'b1000, "rot_g3");
    step(4'b1111, A5, D1X, 1'b0, 1'b0, 4'b0001, "rot_g0b");
    step(4'b0000, A5, D1X, 1'b0, 1'b0, 4'b0000, "rot_idle");

    // Single requester 2 for one cycle; write next cycle, then enable drops.
    step(4'b0100, A_FF, D_A5, 1'b0, 1'b0, 4'b0100, "solo_g2");
    step(4'b0000, A_FF, D_A5, 1'b0, 1'b0, 4'b0000, "solo_idle");
    step(4'b0000, A_FF, D_A5, 1'b0, 1'b0, 4'b0000, "solo_idle2");
    chk("solo_we_low", 32'(write_enable_out), 32'd0);
    chk("solo_addr_hold", 32'(write_register_address_out), 32'hFF);
    chk("solo_data_hold", 32'(write_data_out), 32'hA5);

    // Pointer is 3: requesters 0 and 3 valid -> 3 then 0.
    step(4'b1001, A_MIX, D_MIX, 1'b0, 1'b0, 4'b1000, "wrap_g3");
    step(4'b1001, A_MIX, D_MIX, 1'b0, 1'b0, 4'b0001, "wrap_g0");
    // Pointer 1: 1 and 2 valid -> 1; then 2 drops out and 0 is taken instead.
    step(4'b0110, A_MIX, D_MIX, 1'b0, 1'b0, 4'b0010, "drop_g1");
    step(4'b0001, A_MIX, D_MIX, 1'b0, 1'b0, 4'b0001, "drop_g0");

    // Pointer 1: clear together with requester 1; its write goes first, then the sweep.
    step(4'b0010, A_MIX, D_MIX, 1'b1, 1'b0, 4'b0010, "clr_g1");
    push_sweep();
    for (int i = 0; i < 256; i++) begin
      step(4'b1111, A_MIX, D_MIX, (i == 100), 1'b0, 4'b0000, "sweep_ready");
      chk("sweep_busy", 32'(busy_out), 32'd1);
    end
    // Back in IDLE with pointer 2 (frozen); second clear pulse was ignored.
    step(4'b1111, A_MIX, D_MIX, 1'b0, 1'b0, 4'b0100, "post_sweep_g2");
    chk("post_sweep_busy", 32'(busy_out), 32'd0);
    step(4'b0000, A_MIX, D_MIX, 1'b0, 1'b0, 4'b0000, "post_sweep_idle");
    chk("post_sweep_done_low", 32'(clear_done_out), 32'd0);
    chk("post_sweep_q", 32'(exp_q.size()), 32'd0);

    // Second sweep aborted by reset at address 40.
    step(4'b0000, A_MIX, D_MIX, 1'b1, 1'b0, 4'b0000, "clr2_start");
    push_sweep();
    for (int i = 0; i < 40; i++) begin
      step(4'b0000, A_MIX, D_MIX, 1'b0, 1'b0, 4'b0000, "sweep2_ready");
    end
    step(4'b1111, A_MIX, D_MIX, 1'b0, 1'b1, 4'b0000, "abort_rst");
    exp_q.delete();
    step(4'b1111, A_MIX, D_MIX, 1'b0, 1'b0, 4'b0001, "abort_g0");
    chk("abort_we",   32'(write_enable_out), 32'd0);
    chk("abort_busy", 32'(busy_out), 32'd0);
    chk("abort_done", 32'(clear_done_out), 32'd0);
    step(4'b0000, A_MIX, D_MIX, 1'b0, 1'b0, 4'b0000, "final_idle");
    step(4'b0000, A_MIX, D_MIX, 1'b0, 1'b0, 4'b0000, "final_idle2");
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_register_file_write_arbiter.md
CPU_REGISTER_FILE_WRITE_ARBITER -- requirements
Module: cpu_register_file_write_arbiter

Interface
REQ-001 SHALL have parameter NUMBER_OF_REGISTERS, default 256, giving the register count; AW = $clog2(NUMBER_OF_REGISTERS).
REQ-002 SHALL have parameter NUMBER_OF_REQUESTERS, default 4, giving the write requester count (2..8).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clock_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_in  input  1  synchronous, active-high reset.
REQ-006 request_valid_in  input  NUMBER_OF_REQUESTERS  per-requester write request.
REQ-007 request_address_in  input  NUMBER_OF_REQUESTERS*AW  packed target addresses; requester k occupies bits [k*AW +: AW].
REQ-008 request_data_in  input  NUMBER_OF_REQUESTERS*8  packed write data; requester k occupies bits [k*8 +: 8].
REQ-009 request_ready_out  output  NUMBER_OF_REQUESTERS  one-hot or zero grant; a transfer occurs when valid and ready are both high.
REQ-010 clear_start_in  input  1  single-cycle pulse that requests zeroing of every register.
REQ-011 write_enable_out  output  1  drives the register file write enable.
REQ-012 write_register_address_out  output  AW  drives the register file write address.
REQ-013 write_data_out  output  8  drives the register file write data.
REQ-014 busy_out  output  1  high while a clear sweep is in progress.
REQ-015 clear_done_out  output  1  single-cycle pulse when a sweep completes.

Function
REQ-016 The block SHALL have two states, IDLE and CLEAR.
REQ-017 In IDLE, request_ready_out SHALL be combinational from request_valid_in and the round-robin pointer. At most one bit SHALL be high.
REQ-018 Round-robin arbitration SHALL search requesters starting at the pointer, ascending, wrapping from NUMBER_OF_REQUESTERS-1 to 0. The first requester with valid high SHALL be granted.
REQ-019 After a grant to requester k, the pointer SHALL become (k+1) mod NUMBER_OF_REQUESTERS. With no grant, the pointer SHALL be unchanged.
REQ-020 Write outputs SHALL be registered with 1-cycle latency: a transfer in cycle t produces write_enable_out=1 with that requester's address and data in cycle t+1.
REQ-021 In any cycle with no transfer and no clear write, write_enable_out SHALL be 0 and the address/data outputs SHALL hold their previous values.
REQ-022 Requesters SHALL hold valid, address and data stable until accepted. The arbiter SHALL NOT depend on ready to drive valid.
REQ-023 A clear_start_in pulse in IDLE SHALL move the state to CLEAR on the next edge. A transfer granted in that same cycle SHALL still complete normally.
REQ-024 In CLEAR, request_ready_out SHALL be all-zero and busy_out SHALL be 1.
REQ-025 In CLEAR, a counter from 0 to NUMBER_OF_REGISTERS-1 SHALL drive one zero-write per cycle: write_enable_out=1, address=counter, data=8'h00, each appearing one cycle after the counter value, per REQ-020.
REQ-026 After the write for address NUMBER_OF_REGISTERS-1 is issued, the state SHALL return to IDLE and clear_done_out SHALL pulse high for exactly one cycle, coincident with that final write on the outputs.
REQ-027 A sweep SHALL take exactly NUMBER_OF_REGISTERS cycles in CLEAR.
REQ-028 clear_start_in SHALL be ignored while in CLEAR.
REQ-029 The round-robin pointer SHALL be frozen during CLEAR.
REQ-030 The counter SHALL reset to 0 on each CLEAR entry.
REQ-031 Simultaneous valid on all requesters SHALL yield strict rotation: each requester is granted once every NUMBER_OF_REQUESTERS cycles.
REQ-032 Deasserting a requester's valid SHALL remove it from arbitration in the same cycle.

Reset
REQ-033 While reset_in is high at an edge, the block SHALL enter IDLE with pointer=0 and counter=0.
REQ-034 While reset_in is high at an edge, write_enable_out, write_register_address_out, write_data_out, busy_out and clear_done_out SHALL all become 0.
REQ-035 request_ready_out SHALL be all-zero while reset_in is high.
REQ-036 Reset asserted mid-sweep SHALL abort the sweep with no clear_done_out pulse.
REQ-037 Reset SHALL take precedence over clear_start_in and request_valid_in in the same cycle.

Verification
REQ-038 Reset, then all four valid with data 8'h10/8'h11/8'h12/8'h13 at address 5 held high -> grants in order 0,1,2,3,0. Data 8'h10,8'h11,8'h12,8'h13,8'h10 appears at address 5 one cycle after each grant.
REQ-039 Only requester 2 valid, address 8'hFF, data 8'hA5, for one cycle -> ready=4'b0100 that cycle. The next cycle shows write_enable_out=1, address 8'hFF, data 8'hA5. The cycle after shows write_enable_out=0.
REQ-040 Pointer at 3 with requesters 0 and 3 valid -> 3 granted, then 0 (wrap-around).
REQ-041 clear_start_in together with requester 1 valid -> requester 1 write issued first. Then 256 consecutive zero-writes to addresses 0..255 occur with busy_out=1 and ready all-zero. clear_done_out pulses once with the write to address 255.
REQ-042 Second clear_start_in at sweep address 100 -> ignored; sweep length stays 256 cycles.
REQ-043 reset_in at sweep address 40 -> next cycle write_enable_out=0, busy_out=0, no clear_done_out, and grants resume from requester 0.
